// File: rtl/pc_update_unit.sv
// Program-counter stage of the multicycle CPU.
// It registers the selected next PC and resolves the conditional branches from the ALU flags.
// It rejects misaligned PC writes, records EPC and cause on each exception, and holds PC writes
// until the exception vector has been loaded.
module pc_update_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          next_pc,
    input  logic                 pc_write,
    input  logic                 pc_write_cond,
    input  logic [1:0]           branch_op,
    input  logic                 alu_zero,
    input  logic                 alu_gt,
    input  logic                 exc_req,
    input  logic [1:0]           exc_cause_in,
    output logic [31:0]          pc_out,
    output logic [31:0]          epc_out,
    output logic [1:0]           cause_out,
    output logic                 exc_busy,
    output logic                 pc_misaligned,
    output logic [CNT_WIDTH-1:0] exc_count
);

    typedef enum logic {StNormal, StExcHold} state_e;

    localparam logic [1:0] CauseMisaligned = 2'b11;

    state_e               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          epc_q, epc_d;
    logic [1:0]           cause_q, cause_d;
    logic                 mis_q, mis_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 cond;
    logic                 wr;
    logic [CNT_WIDTH-1:0] cnt_inc;

    // Branch condition from the ALU flags, then the combined write request.
    always_comb begin
        cond = 1'b0;
        unique case (branch_op)
            2'b00:   cond = alu_zero;
            2'b01:   cond = ~alu_zero;
            2'b10:   cond = alu_gt;
            default: cond = ~alu_gt;
        endcase
        wr = pc_write | (pc_write_cond & cond);
        // The counter sticks at all-ones instead of wrapping.
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    end

    // Next-state logic: exception capture, alignment check and PC update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        mis_d   = 1'b0;
        unique case (state_q)
            StNormal: begin
                if (exc_req) begin
                    epc_d   = pc_q - 32'd4;
                    cause_d = exc_cause_in;
                    cnt_d   = cnt_inc;
                    state_d = StExcHold;
                end else if (wr && (next_pc[1:0] != 2'b00)) begin
                    epc_d   = pc_q - 32'd4;
                    cause_d = CauseMisaligned;
                    cnt_d   = cnt_inc;
                    mis_d   = 1'b1;
                    state_d = StExcHold;
                end else if (wr) begin
                    pc_d = next_pc;
                end
            end
            StExcHold: begin
                // Only the handler vector load leaves this state; it is trusted, so it is not
                // checked for alignment.
                if (pc_write) begin
                    pc_d    = next_pc;
                    state_d = StNormal;
                end
            end
            default: state_d = StNormal;
        endcase
    end

    // State and output registers; reset aborts any exception in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StNormal;
            pc_q    <= RESET_PC;
            epc_q   <= 32'h0;
            cause_q <= 2'b00;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_out        = pc_q;
    assign epc_out       = epc_q;
    assign cause_out     = cause_q;
    assign exc_busy      = (state_q == StExcHold);
    assign pc_misaligned = mis_q;
    assign exc_count     = cnt_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed bench for pc_update_unit: each task drives one scenario and checks inline.
module tb_pc_update_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] next_pc;
    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  branch_op;
    logic        alu_zero;
    logic        alu_gt;
    logic        exc_req;
    logic [1:0]  exc_cause_in;
    logic [31:0] pc_out;
    logic [31:0] epc_out;
    logic [1:0]  cause_out;
    logic        exc_busy;
    logic        pc_misaligned;
    logic [7:0]  exc_count;

    int total = 0;
    int bad   = 0;

    pc_update_unit #(
        .RESET_PC (32'h0000_0000),
        .CNT_WIDTH(8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .next_pc      (next_pc),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .branch_op    (branch_op),
        .alu_zero     (alu_zero),
        .alu_gt       (alu_gt),
        .exc_req      (exc_req),
        .exc_cause_in (exc_cause_in),
        .pc_out       (pc_out),
        .epc_out      (epc_out),
        .cause_out    (cause_out),
        .exc_busy     (exc_busy),
        .pc_misaligned(pc_misaligned),
        .exc_count    (exc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        next_pc       = 32'h0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_op     = 2'b00;
        alu_zero      = 1'b0;
        alu_gt        = 1'b0;
        exc_req       = 1'b0;
        exc_cause_in  = 2'b00;
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        #12;
        total++;
        if (pc_out !== 32'h0 || epc_out !== 32'h0 || cause_out !== 2'b00 || exc_busy !== 1'b0
            || pc_misaligned !== 1'b0 || exc_count !== 8'h00) begin
            bad++;
            $display("FAIL reset_values: pc=%h epc=%h cause=%b busy=%b mis=%b cnt=%h, want all 0",
                     pc_out, epc_out, cause_out, exc_busy, pc_misaligned, exc_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        total++;
        if (pc_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_idle_hold: pc=%h want 00000000", pc_out);
        end
    endtask

    task automatic test_jump();
        next_pc  = 32'h0000_0004;
        pc_write = 1'b1;
        step();
        idle_inputs();
        total++;
        if (pc_out !== 32'h4 || exc_busy !== 1'b0) begin
            bad++;
            $display("FAIL jump: pc=%h busy=%b want 00000004 0", pc_out, exc_busy);
        end
    endtask

    task automatic test_branch();
        logic [1:0]  ops  [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
        logic        zs   [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        gts  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] npcs [8] = '{32'h40, 32'h80, 32'h80, 32'hC0, 32'hC0, 32'h100, 32'h100,
                                  32'h140};
        logic [31:0] exps [8] = '{32'h40, 32'h40, 32'h80, 32'h80, 32'hC0, 32'hC0, 32'h100,
                                  32'h100};
        for (int i = 0; i < 8; i++) begin
            pc_write_cond = 1'b1;
            branch_op     = ops[i];
            alu_zero      = zs[i];
            alu_gt        = gts[i];
            next_pc       = npcs[i];
            step();
            idle_inputs();
            total++;
            if (pc_out !== exps[i]) begin
                bad++;
                $display("FAIL branch[%0d] op=%b: pc=%h want %h", i, ops[i], pc_out, exps[i]);
            end
        end
    endtask

    task automatic test_exc_priority();
        // PC is 0x100 here; exception wins over a same-cycle pc_write.
        exc_req      = 1'b1;
        exc_cause_in = 2'b01;
        pc_write     = 1'b1;
        next_pc      = 32'h200;
        step();
        idle_inputs();
        total++;
        if (epc_out !== 32'hFC || cause_out !== 2'b01 || pc_out !== 32'h100 || exc_busy !== 1'b1
            || exc_count !== 8'd1 || pc_misaligned !== 1'b0) begin
            bad++;
            $display("FAIL exc_capture: epc=%h cause=%b pc=%h busy=%b cnt=%h mis=%b want 000000fc 01 00000100 1 01 0",
                     epc_out, cause_out, pc_out, exc_busy, exc_count, pc_misaligned);
        end
        // Taken branch is ignored while holding.
        pc_write_cond = 1'b1;
        branch_op     = 2'b00;
        alu_zero      = 1'b1;
        next_pc       = 32'h300;
        step();
        idle_inputs();
        total++;
        if (pc_out !== 32'h100 || exc_busy !== 1'b1) begin
            bad++;
            $display("FAIL hold_ignores_cond: pc=%h busy=%b want 00000100 1", pc_out, exc_busy);
        end
        pc_write = 1'b1;
        next_pc  = 32'h8000_0000;
        step();
        idle_inputs();
        total++;
        if (pc_out !== 32'h8000_0000 || exc_busy !== 1'b0 || epc_out !== 32'hFC) begin
            bad++;
            $display("FAIL vector_load: pc=%h busy=%b epc=%h want 80000000 0 000000fc",
                     pc_out, exc_busy, epc_out);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        pc_write = 1'b1;
        next_pc  = 32'h0000_0042;
        step();
        idle_inputs();
        total++;
        if (pc_misaligned !== 1'b1 || cause_out !== 2'b11 || pc_out !== 32'h0
            || epc_out !== 32'hFFFF_FFFC || exc_busy !== 1'b1 || exc_count !== 8'd1) begin
            bad++;
            $display("FAIL misaligned: mis=%b cause=%b pc=%h epc=%h busy=%b cnt=%h want 1 11 00000000 fffffffc 1 01",
                     pc_misaligned, cause_out, pc_out, epc_out, exc_busy, exc_count);
        end
        exc_req      = 1'b1;
        exc_cause_in = 2'b10;
        step();
        idle_inputs();
        total++;
        if (cause_out !== 2'b11 || exc_count !== 8'd1 || pc_misaligned !== 1'b0
            || epc_out !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL busy_ignores_exc: cause=%b cnt=%h mis=%b epc=%h want 11 01 0 fffffffc",
                     cause_out, exc_count, pc_misaligned, epc_out);
        end
        // Vector write in hold skips the alignment check.
        pc_write = 1'b1;
        next_pc  = 32'h0000_0043;
        step();
        idle_inputs();
        total++;
        if (pc_out !== 32'h43 || exc_busy !== 1'b0 || pc_misaligned !== 1'b0) begin
            bad++;
            $display("FAIL trusted_vector: pc=%h busy=%b mis=%b want 00000043 0 0",
                     pc_out, exc_busy, pc_misaligned);
        end
        // Misaligned taken branch is also rejected.
        pc_write_cond = 1'b1;
        branch_op     = 2'b01;
        alu_zero      = 1'b0;
        next_pc       = 32'h0000_0081;
        step();
        idle_inputs();
        total++;
        if (pc_misaligned !== 1'b1 || pc_out !== 32'h43 || epc_out !== 32'h3F
            || exc_count !== 8'd2) begin
            bad++;
            $display("FAIL misaligned_branch: mis=%b pc=%h epc=%h cnt=%h want 1 00000043 0000003f 02",
                     pc_misaligned, pc_out, epc_out, exc_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [3] = '{32'h8, 32'hC, 32'h10};
        // Leave the hold left by the previous task.
        pc_write = 1'b1;
        next_pc  = 32'h4;
        step();
        for (int i = 0; i < 3; i++) begin
            pc_write = 1'b1;
            next_pc  = seq[i];
            step();
            total++;
            if (pc_out !== seq[i] || exc_busy !== 1'b0) begin
                bad++;
                $display("FAIL back_to_back[%0d]: pc=%h busy=%b want %h 0",
                         i, pc_out, exc_busy, seq[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        exc_req      = 1'b1;
        exc_cause_in = 2'b00;
        step();
        idle_inputs();
        total++;
        if (epc_out !== 32'hFFFF_FFFC || exc_count !== 8'd1 || cause_out !== 2'b00) begin
            bad++;
            $display("FAIL wrap_epc: epc=%h cnt=%h cause=%b want fffffffc 01 00",
                     epc_out, exc_count, cause_out);
        end
        for (int i = 0; i < 256; i++) begin
            pc_write = 1'b1;
            next_pc  = 32'h0;
            step();
            idle_inputs();
            exc_req      = 1'b1;
            exc_cause_in = 2'b10;
            step();
            idle_inputs();
            if (i == 253) begin
                total++;
                if (exc_count !== 8'hFF) begin
                    bad++;
                    $display("FAIL count_reach_ff: cnt=%h want ff", exc_count);
                end
            end
        end
        total++;
        if (exc_count !== 8'hFF || cause_out !== 2'b10 || exc_busy !== 1'b1) begin
            bad++;
            $display("FAIL count_saturate: cnt=%h cause=%b busy=%b want ff 10 1",
                     exc_count, cause_out, exc_busy);
        end
    endtask

    task automatic test_async_reset();
        // Still in hold from the previous task; reset lands between clock edges.
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (pc_out !== 32'h0 || epc_out !== 32'h0 || cause_out !== 2'b00 || exc_busy !== 1'b0
            || pc_misaligned !== 1'b0 || exc_count !== 8'h00) begin
            bad++;
            $display("FAIL async_reset: pc=%h epc=%h cause=%b busy=%b mis=%b cnt=%h want all 0",
                     pc_out, epc_out, cause_out, exc_busy, pc_misaligned, exc_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        pc_write = 1'b1;
        next_pc  = 32'h20;
        step();
        idle_inputs();
        total++;
        if (pc_out !== 32'h20 || exc_busy !== 1'b0) begin
            bad++;
            $display("FAIL after_reset_write: pc=%h busy=%b want 00000020 0", pc_out, exc_busy);
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_branch();
        test_exc_priority();
        test_misaligned();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
